// File: rtl/cla_pkg.sv
// Shared definitions for the pipelined CLA adder: legality check, slice sizing,
// per-stage control record and saturation constants.
package cla_pkg;

  localparam int MAX_W = 1024;

  typedef struct packed {
    logic vld;
    logic carry;
    logic sub;
  } stage_ctl_t;

  function automatic bit params_ok(int width, int stages, int group);
    if (width <= 0 || stages <= 0 || group <= 0) return 1'b0;
    if (width % stages != 0) return 1'b0;
    return ((width / stages) % group) == 0;
  endfunction

  function automatic int slice_w(int width, int stages);
    return width / stages;
  endfunction

  function automatic logic [MAX_W-1:0] sat_max(int width);
    logic [MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < width - 1; i++) r[i] = 1'b1;
    return r;
  endfunction

  function automatic logic [MAX_W-1:0] sat_min(int width);
    logic [MAX_W-1:0] r;
    r = '0;
    r[width-1] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/cla_slice.sv
// Combinational SLICE-bit carry-lookahead adder built from GROUP-bit P/G blocks
// with a second lookahead level across the groups.
module cla_slice
  import cla_pkg::*;
#(
  parameter int SLICE = 8,
  parameter int GROUP = 4
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] s,
  output logic             cout,
  output logic             c_msb_in
);

  localparam int NGRP = SLICE / GROUP;

  logic [SLICE-1:0] p;
  logic [SLICE-1:0] g;
  logic [NGRP-1:0]  gp;
  logic [NGRP-1:0]  gg;
  logic [NGRP:0]    gc;
  logic [SLICE:0]   c;

  assign p = a ^ b;
  assign g = a & b;

  always_comb begin
    gp = '1;
    gg = '0;
    for (int j = 0; j < NGRP; j++) begin
      for (int i = 0; i < GROUP; i++) begin
        gg[j] = g[j*GROUP+i] | (p[j*GROUP+i] & gg[j]);
        gp[j] = gp[j] & p[j*GROUP+i];
      end
    end
  end

  always_comb begin
    gc    = '0;
    gc[0] = cin;
    for (int j = 0; j < NGRP; j++) gc[j+1] = gg[j] | (gp[j] & gc[j]);
  end

  // Group carries come from the lookahead level; bit carries only span one group.
  always_comb begin
    c = '0;
    for (int j = 0; j < NGRP; j++) begin
      c[j*GROUP] = gc[j];
      for (int i = 0; i < GROUP - 1; i++)
        c[j*GROUP+i+1] = g[j*GROUP+i] | (p[j*GROUP+i] & c[j*GROUP+i]);
    end
    c[SLICE] = gc[NGRP];
  end

  assign s        = p ^ c[SLICE-1:0];
  assign cout     = c[SLICE];
  assign c_msb_in = c[SLICE-1];

endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined CLA adder/subtractor: stage k adds slice k, carries are registered between stages.
// Build option: define CLA_PIPE_SAT_EN to clamp signed overflow to the signed max/min.
module cla_pipe_adder
  import cla_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4,
  parameter int GROUP  = 4
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  input  logic             sub_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             ovf_o
);

  localparam int SLICE = slice_w(WIDTH, STAGES);
  localparam int NREG  = (STAGES > 1) ? STAGES - 1 : 1;
  localparam int LAST  = STAGES - 1;

  if (!params_ok(WIDTH, STAGES, GROUP)) begin : g_param_check
    $error("cla_pipe_adder: illegal WIDTH/STAGES/GROUP combination");
  end

  logic             adv;
  stage_ctl_t       ctl_p [NREG];
  logic [WIDTH-1:0] a_p   [NREG];
  logic [WIDTH-1:0] b_p   [NREG];
  logic [WIDTH-1:0] sum_p [NREG];

  logic             vld_s  [STAGES];
  logic             cin_s  [STAGES];
  logic             sub_s  [STAGES];
  logic             cout_s [STAGES];
  logic             cmsb_s [STAGES];
  logic [WIDTH-1:0] a_s    [STAGES];
  logic [WIDTH-1:0] b_s    [STAGES];
  logic [WIDTH-1:0] sum_s  [STAGES];
  logic [WIDTH-1:0] sum_n  [STAGES];
  logic [SLICE-1:0] slice_sum [STAGES];

  logic             ovf_n;
  logic [WIDTH-1:0] sum_fin;

  assign adv        = !out_valid_o || out_ready_i;
  assign in_ready_o = adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam logic [WIDTH-1:0] MASK = WIDTH'({SLICE{1'b1}}) << (k * SLICE);

    if (k == 0) begin : g_head
      assign vld_s[k] = in_valid_i;
      assign a_s[k]   = a_i;
      assign b_s[k]   = b_i;
      assign sum_s[k] = '0;
      assign sub_s[k] = sub_i;
      assign cin_s[k] = sub_i | cin_i;
    end else begin : g_body
      assign vld_s[k] = ctl_p[k-1].vld;
      assign a_s[k]   = a_p[k-1];
      assign b_s[k]   = b_p[k-1];
      assign sum_s[k] = sum_p[k-1];
      assign sub_s[k] = ctl_p[k-1].sub;
      assign cin_s[k] = ctl_p[k-1].carry;
    end

    cla_slice #(.SLICE(SLICE), .GROUP(GROUP)) u_slice (
      .a        (a_s[k][k*SLICE +: SLICE]),
      .b        (b_s[k][k*SLICE +: SLICE] ^ {SLICE{sub_s[k]}}),
      .cin      (cin_s[k]),
      .s        (slice_sum[k]),
      .cout     (cout_s[k]),
      .c_msb_in (cmsb_s[k])
    );

    assign sum_n[k] = (sum_s[k] & ~MASK) | (WIDTH'(slice_sum[k]) << (k * SLICE));
  end

  // Inter-stage boundary: control record (reset) and skewed operands/partial sums (no reset).
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      for (int k = 0; k < NREG; k++) ctl_p[k] <= '0;
    end else if (adv) begin
      for (int k = 0; k < STAGES - 1; k++)
        ctl_p[k] <= '{vld: vld_s[k], carry: cout_s[k], sub: sub_s[k]};
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (adv) begin
      for (int k = 0; k < STAGES - 1; k++) begin
        a_p[k]   <= a_s[k];
        b_p[k]   <= b_s[k];
        sum_p[k] <= sum_n[k];
      end
    end
  end

  assign ovf_n = cmsb_s[LAST] ^ cout_s[LAST];

`ifdef CLA_PIPE_SAT_EN
  localparam logic [WIDTH-1:0] SAT_MAX = WIDTH'(sat_max(WIDTH));
  localparam logic [WIDTH-1:0] SAT_MIN = WIDTH'(sat_min(WIDTH));

  // Overflow direction follows the sign of operand A.
  assign sum_fin = !ovf_n ? sum_n[LAST] : (a_s[LAST][WIDTH-1] ? SAT_MIN : SAT_MAX);
`else
  assign sum_fin = sum_n[LAST];
`endif

  // Output boundary: held while the consumer stalls.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      out_valid_o <= 1'b0;
      sum_o       <= '0;
      cout_o      <= 1'b0;
      ovf_o       <= 1'b0;
    end else if (adv) begin
      out_valid_o <= vld_s[LAST];
      sum_o       <= sum_fin;
      cout_o      <= cout_s[LAST];
      ovf_o       <= ovf_n;
    end
  end

endmodule
